// File: rtl/aes_pkg.sv
// Shared AES inverse-round constants, FSM state type and GF(2^8) helpers.
package aes_pkg;

  localparam int WORD    = 32;
  localparam int NB      = 4;
  localparam int BLOCK_W = WORD * NB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the four InvMixColumns coefficients are supported.
  function automatic logic [7:0] gmul_inv(input logic [7:0] b, input logic [7:0] coef);
    logic [7:0] x2, x4, x8, res;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (coef)
      8'h09:   res = x8 ^ b;
      8'h0b:   res = x8 ^ x2 ^ b;
      8'h0d:   res = x8 ^ x4 ^ b;
      8'h0e:   res = x8 ^ x4 ^ x2;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  // Output row r, column c takes input row r, column (c - r) mod 4.
  function automatic logic [BLOCK_W-1:0] inv_shiftrows(input logic [BLOCK_W-1:0] blk);
    logic [BLOCK_W-1:0] res;
    res = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127 - 32*c - 8*r -: 8] = blk[127 - 32*((c - r + 4) % 4) - 8*r -: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/inv_mixcolumn.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in the top byte).
module inv_mixcolumn
  import aes_pkg::*;
(
  input  logic [WORD-1:0] col_in,
  output logic [WORD-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign col_out[31:24] = gmul_inv(a0, 8'h0e) ^ gmul_inv(a1, 8'h0b) ^
                          gmul_inv(a2, 8'h0d) ^ gmul_inv(a3, 8'h09);
  assign col_out[23:16] = gmul_inv(a1, 8'h0e) ^ gmul_inv(a2, 8'h0b) ^
                          gmul_inv(a3, 8'h0d) ^ gmul_inv(a0, 8'h09);
  assign col_out[15:8]  = gmul_inv(a2, 8'h0e) ^ gmul_inv(a3, 8'h0b) ^
                          gmul_inv(a0, 8'h0d) ^ gmul_inv(a1, 8'h09);
  assign col_out[7:0]   = gmul_inv(a3, 8'h0e) ^ gmul_inv(a0, 8'h0b) ^
                          gmul_inv(a1, 8'h0d) ^ gmul_inv(a2, 8'h09);

endmodule

// File: rtl/inv_round_lin.sv
// Linear half of an AES inverse round: InvShiftRows, AddRoundKey, column-serial InvMixColumns.
// Define INV_ROUND_KEY_XOR_EN to include the round-key XOR; otherwise i_key is ignored.
//
// state | meaning
// IDLE  | ready for a new block
// MIX   | InvMixColumns on column col_cnt, one column per cycle
// DONE  | o_block valid, held until downstream accepts
module inv_round_lin
  import aes_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BLOCK_W-1:0] i_block,
  input  logic [BLOCK_W-1:0] i_key,
  input  logic               i_last,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BLOCK_W-1:0] o_block
);

`ifdef INV_ROUND_KEY_XOR_EN
  localparam logic [BLOCK_W-1:0] KEY_MASK = '1;
`else
  localparam logic [BLOCK_W-1:0] KEY_MASK = '0;
`endif

  state_t             state, state_nxt;
  logic [1:0]         col_cnt;
  logic [BLOCK_W-1:0] s_reg;
  logic [BLOCK_W-1:0] s_load;
  logic [WORD-1:0]    col_cur, col_mix;
  logic               accept;

  assign accept  = i_valid && o_ready;
  assign s_load  = inv_shiftrows(i_block) ^ (i_key & KEY_MASK);
  assign o_block = s_reg;

  always_comb begin
    col_cur = s_reg[127:96];
    case (col_cnt)
      2'd0: col_cur = s_reg[127:96];
      2'd1: col_cur = s_reg[95:64];
      2'd2: col_cur = s_reg[63:32];
      2'd3: col_cur = s_reg[31:0];
      default: col_cur = s_reg[127:96];
    endcase
  end

  inv_mixcolumn u_mix (
    .col_in  (col_cur),
    .col_out (col_mix)
  );

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = i_last ? DONE : MIX;
      end
      MIX: begin
        if (col_cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
      s_reg   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        s_reg   <= s_load;
        col_cnt <= 2'd0;
      end else if (state == MIX) begin
        // Columns are independent, so the in-place write-back is safe.
        case (col_cnt)
          2'd0: s_reg[127:96] <= col_mix;
          2'd1: s_reg[95:64]  <= col_mix;
          2'd2: s_reg[63:32]  <= col_mix;
          2'd3: s_reg[31:0]   <= col_mix;
          default: ;
        endcase
        col_cnt <= col_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_inv_round_lin.sv
// Directed self-checking bench for inv_round_lin (default and INV_ROUND_KEY_XOR_EN builds).
module tb_inv_round_lin;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_block;
  logic [127:0] i_key;
  logic         i_last;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_block;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] LAST_IN  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] LAST_EXP = 128'h000d0a07_04010e0b_0805020f_0c090603;
  localparam logic [127:0] MIX_IN   = 128'h9f4dc601_8ec6019d_c60158bc_01dca1c6;
  localparam logic [127:0] MIX_EXP  = 128'hf20a225c_db135345_c6c6c6c6_01010101;
`ifdef INV_ROUND_KEY_XOR_EN
  localparam logic [127:0] KEY_EXP  = {128{1'b1}};
`else
  localparam logic [127:0] KEY_EXP  = 128'h0;
`endif

  always #5 i_clk = ~i_clk;

  inv_round_lin dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_block (i_block),
    .i_key   (i_key),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_block (o_block)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Presents one block for a single accepting edge; leaves the bench in cycle k+1.
  task automatic send(input logic [127:0] blk, input logic [127:0] key, input logic last);
    i_block = blk;
    i_key   = key;
    i_last  = last;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_block !== 128'h0) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: got valid=%b ready=%b block=%h, want valid=0 ready=1 block=0",
                 i, o_valid, o_ready, o_block);
      end
      tick();
    end
  endtask

  task automatic test_last_round();
    send(LAST_IN, 128'h0, 1'b1);
    n_cmp++;
    if (o_valid !== 1'b1 || o_block !== LAST_EXP) begin
      n_bad++;
      $display("FAIL last_round: got valid=%b block=%h, want valid=1 block=%h", o_valid, o_block, LAST_EXP);
    end
    tick();
  endtask

  task automatic test_mix();
    send(MIX_IN, 128'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL mix_busy k+%0d: got valid=%b ready=%b, want valid=0 ready=0", i, o_valid, o_ready);
      end
      tick();
    end
    n_cmp++;
    if (o_valid !== 1'b1 || o_block !== MIX_EXP) begin
      n_bad++;
      $display("FAIL mix_result: got valid=%b block=%h, want valid=1 block=%h", o_valid, o_block, MIX_EXP);
    end
    tick();
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    send(MIX_IN, 128'h0, 1'b0);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_block !== MIX_EXP) begin
        n_bad++;
        $display("FAIL backpressure_hold %0d: got valid=%b ready=%b block=%h, want valid=1 ready=0 block=%h",
                 i, o_valid, o_ready, o_block, MIX_EXP);
      end
      if (i < 2) tick();
    end
    i_ready = 1'b1;
    tick();
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_release: got valid=%b ready=%b, want valid=0 ready=1", o_valid, o_ready);
    end
  endtask

  task automatic test_key();
    send(128'h0, {128{1'b1}}, 1'b1);
    n_cmp++;
    if (o_valid !== 1'b1 || o_block !== KEY_EXP) begin
      n_bad++;
      $display("FAIL key_xor: got valid=%b block=%h, want valid=1 block=%h", o_valid, o_block, KEY_EXP);
    end
    tick();
  endtask

  task automatic test_reset_mid_mix();
    send(MIX_IN, 128'h0, 1'b0);
    tick();
    tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_block !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_mid_mix: got valid=%b ready=%b block=%h, want valid=0 ready=1 block=0",
               o_valid, o_ready, o_block);
    end
    test_mix();
  endtask

  task automatic test_back_to_back();
    i_block = LAST_IN;
    i_key   = 128'h0;
    i_last  = 1'b1;
    i_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (o_valid !== ((i % 2) == 0) || o_ready !== ((i % 2) == 1)) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: got valid=%b ready=%b, want valid=%b ready=%b",
                 i, o_valid, o_ready, (i % 2) == 0, (i % 2) == 1);
      end
    end
    i_valid = 1'b0;
    tick();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_block = '0;
    i_key   = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    #1;
    test_reset();
    test_last_round();
    test_mix();
    test_backpressure();
    test_key();
    test_reset_mid_mix();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
